pwm_dac: RTL and testbench
==========================

# pwm_dac

Output stage of the synth voice path. It consumes the unsigned 16-bit modulated sample produced by the oscillator modulation stage and drives a single-pin PWM audio output. One sample is taken per PWM period. First-order error feedback carries the sample bits below PWM resolution into later periods, so low-order detail survives as noise-shaped duty dither.

## Interface
- `o`, default 16: sample width in bits (unsigned, offset-binary).
- `r`, default 8: PWM resolution in bits. The period is 2^r clocks. Requires r < o.

- `clk`, input, 1: system clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `en`, input, 1: run enable. Low holds the stage idle and silent.
- `sample`, input, o: modulated sample from the upstream modulation stage. Sampled only at period load.
- `pwm_out`, output, 1: PWM audio bit, registered.
- `period_start`, output, 1: registered one-cycle strobe in the first cycle of every PWM period.

## Operation
- Registers:
  - `cnt` (r bits): period counter.
  - `duty` (r bits): current duty.
  - `err` (o-r bits): residual carried between periods.
  - `pwm_out` and `period_start`.
- Idle (`rst_n`=0, or `en`=0):
  - `cnt` = 2^r-1, `duty` = 0, `err` = 0, `pwm_out` = 0, `period_start` = 0.
  - Reset takes priority over `en`.
- Run (`en`=1), each clock:
  - If `cnt` = 2^r-1, perform a load: `cnt` goes to 0 and `duty` is recomputed. Otherwise `cnt` increments by 1.
- Load arithmetic, computed in o+1 bits: `sum` = `sample` + zero-extended `err`.
  - If `sum[o]` = 0: `duty` = `sum[o-1:o-r]` and `err` = `sum[o-r-1:0]`.
  - If `sum[o]` = 1 (overflow): saturate, with `duty` = 2^r-1 and `err` = 0.
- `pwm_out` equals (`cnt` < `duty`), evaluated on the post-edge values of both registers. It is registered from next-state values so that it aligns with `cnt`, with no extra lag. `pwm_out` is 0 whenever idle.
- Duty range:
  - `duty` = 0 gives a permanently low output.
  - `duty` = 2^r-1 gives a high output for 2^r-1 of every 2^r cycles.
  - 100% duty is not reachable.
- `period_start` is 1 exactly in the cycles where `cnt` = 0 following a load. It is 0 otherwise.
- `sample` is treated as unsigned; no sign conversion is applied.

## Timing
- Sample capture: `sample` must be stable during the cycle in which `en`=1 and `cnt`=2^r-1. It is ignored in all other cycles.
- Latency: a sample captured in cycle L affects `pwm_out` starting in cycle L+1, which is also when `period_start`=1.
- Startup: after `rst_n` releases with `en`=1, the first clock edge performs a load. The next cycle has `cnt`=0 and `period_start`=1.
- Strobe spacing: while `en` stays 1, `period_start` strobes are exactly 2^r cycles apart.
- Mid-period `en` drop: on the edge where `en`=0 is seen, `pwm_out` drops to 0 and `cnt`/`duty`/`err` return to idle values. The partial period is discarded.
- Re-enable: reasserting `en` gives a fresh load on the first enabled edge, with `err`=0.
- Mid-period reset: identical to an `en` drop. Every output is 0 on the edge after `rst_n`=0 is sampled.
- Sample changes: a change on `sample` in a non-load cycle has no effect until the next load.

## Test plan
All scenarios use o=16, r=8.

1. **Reset:** hold `rst_n`=0 for 3 cycles with `en`=1 and `sample`=0x8000 -> `pwm_out`=0 and `period_start`=0 throughout. On release, `period_start`=1 on the 2nd cycle after release, then every 256 cycles.
2. **Mid-scale:** `sample`=0x8000 held -> each period has `pwm_out` high for `cnt` 0..127 and low for 128..255. `err` stays 0.
3. **Sub-LSB dither:** `sample`=0x0080 -> period 1 has `duty`=0 with `err`=0x80. Period 2 has `duty`=1, giving a single high cycle at `cnt`=0, with `err`=0. The pattern alternates.
4. **Saturation:** `sample`=0xFFFF -> period 1 has `duty`=255 with `err`=0xFF. Period 2 overflows (`sum`=0x100FE) and saturates to `duty`=255 with `err`=0. `pwm_out` is low only at `cnt`=255.
5. **Zero:** `sample`=0x0000 -> `pwm_out` is never high over 4 periods, while `period_start` still strobes every 256 cycles.
6. **Enable drop:** drop `en` at `cnt`=50 with `sample`=0xC000 -> `pwm_out`=0 on the next cycle and no strobes while idle. Reassert `en` -> a load occurs on the first enabled edge, `period_start` follows one cycle later, and `duty`=192.

Source files
------------

// File: rtl/pwm_dac.sv
// pwm_dac: single-pin PWM audio output stage with first-order error feedback.
// Latency: a sample loaded at the period boundary drives pwm_out from the next cycle.
// Backpressure: none. sample is taken once per 2^r-cycle period, and en=0 idles the stage.
//
// Parameters
//   o            sample width in bits (unsigned, offset-binary)
//   r            PWM resolution in bits; the period is 2^r clocks; requires r < o
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset; takes priority over en
//   en           run enable; low holds the stage idle and silent
//   sample       modulated sample; only looked at in the load cycle (cnt = 2^r-1)
//   pwm_out      registered PWM bit, high while cnt < duty
//   period_start registered strobe, high in the first cycle (cnt = 0) of each period
module pwm_dac #(
  parameter int unsigned o = 16,
  parameter int unsigned r = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [o-1:0] sample,
  output logic         pwm_out,
  output logic         period_start
);

  localparam int unsigned EW = o - r;

  localparam logic [r-1:0]  CNT_MAX  = '1;
  localparam logic [r-1:0]  CNT_ZERO = '0;
  localparam logic [r-1:0]  CNT_ONE  = {{(r-1){1'b0}}, 1'b1};
  localparam logic [r-1:0]  DUTY_SAT = '1;
  localparam logic [EW-1:0] ERR_ZERO = '0;

  logic [r-1:0]  cnt_q,  cnt_d;
  logic [r-1:0]  duty_q, duty_d;
  logic [EW-1:0] err_q,  err_d;
  logic          pwm_q,  pwm_d;
  logic          ps_q,   ps_d;

  logic          load;
  logic [o:0]    sum;
  logic [r-1:0]  load_duty;
  logic [EW-1:0] load_err;

  // The period ends when the counter wraps. This is the only cycle in which
  // sample is consumed.
  assign load = (cnt_q == CNT_MAX);

  // Add the carried residual below PWM resolution to the new sample. One
  // extra bit catches the carry out of the top of the sample range.
  assign sum = {1'b0, sample} + {{(r+1){1'b0}}, err_q};

  always_comb begin
    load_duty = sum[o-1:o-r];
    load_err  = sum[EW-1:0];
    // On overflow, clamp to the largest reachable duty and drop the residual.
    // Keeping the residual would make the stage stick at full scale.
    if (sum[o]) begin
      load_duty = DUTY_SAT;
      load_err  = ERR_ZERO;
    end
  end

  always_comb begin
    cnt_d  = CNT_MAX;
    duty_d = '0;
    err_d  = ERR_ZERO;
    ps_d   = 1'b0;
    pwm_d  = 1'b0;
    if (en) begin
      duty_d = duty_q;
      err_d  = err_q;
      if (load) begin
        cnt_d  = CNT_ZERO;
        duty_d = load_duty;
        err_d  = load_err;
        ps_d   = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_ONE;
      end
      // Compare against next-state values. This keeps the registered output
      // in step with cnt, with no extra cycle of lag.
      pwm_d = (cnt_d < duty_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= CNT_MAX;
      duty_q <= '0;
      err_q  <= ERR_ZERO;
      pwm_q  <= 1'b0;
      ps_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      err_q  <= err_d;
      pwm_q  <= pwm_d;
      ps_q   <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: directed bench for pwm_dac (o=16, r=8).
// Each period is checked cycle by cycle against a hand-computed duty value.
// Inputs change 1 time unit after a rising edge, and outputs are read at that
// same moment.
module tb_pwm_dac;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] sample;
  logic        pwm_out;
  logic        period_start;

  int total = 0;
  int bad   = 0;

  pwm_dac #(.o(16), .r(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sample       (sample),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check ncyc cycles. The first edge inside this task is assumed to be the
  // load edge, so cycle k has cnt = k.
  task automatic run_period(input int duty, input int ncyc, input string name);
    for (int k = 0; k < ncyc; k++) begin
      step();
      total++;
      if (period_start !== (k == 0)) begin
        bad++;
        $display("FAIL %s period_start k=%0d got=%b want=%b", name, k, period_start, (k == 0));
      end
      total++;
      if (pwm_out !== (k < duty)) begin
        bad++;
        $display("FAIL %s pwm_out k=%0d got=%b want=%b", name, k, pwm_out, (k < duty));
      end
    end
  endtask

  task automatic check_idle(input int ncyc, input string name);
    for (int k = 0; k < ncyc; k++) begin
      step();
      total++;
      if (pwm_out !== 1'b0 || period_start !== 1'b0) begin
        bad++;
        $display("FAIL %s idle k=%0d got pwm=%b ps=%b want 0 0", name, k, pwm_out, period_start);
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    en     = 1'b1;
    sample = 16'h8000;
    check_idle(3, "reset");
    rst_n = 1'b1;
    // The first enabled edge loads 0x8000, which gives duty 128.
    // Two periods are checked back to back to confirm the 256-cycle spacing.
    run_period(128, 256, "reset_p1");
    run_period(128, 256, "reset_p2");
  endtask

  task automatic test_midscale();
    sample = 16'h8000;
    run_period(128, 256, "mid_p1");
    run_period(128, 256, "mid_p2");
  endtask

  task automatic test_dither();
    sample = 16'h0080;
    // The residual 0x80 alternates duty between 0 and 1.
    run_period(0, 256, "dith_p1");
    run_period(1, 256, "dith_p2");
    run_period(0, 256, "dith_p3");
    run_period(1, 256, "dith_p4");
  endtask

  task automatic test_saturation();
    sample = 16'hFFFF;
    run_period(255, 256, "sat_p1");  // sum 0xFFFF, err becomes 0xFF
    run_period(255, 256, "sat_p2");  // sum 0x100FE saturates, err becomes 0
    // A residual of 0 after saturation gives 0x00FF -> duty 0, err 0xFF.
    sample = 16'h00FF;
    run_period(0, 256, "sat_err_cleared");
  endtask

  task automatic test_zero();
    sample = 16'h0000;
    // The carried err 0xFF never reaches one LSB, so the output stays low.
    for (int p = 0; p < 4; p++) run_period(0, 256, "zero");
  endtask

  task automatic test_en_drop();
    sample = 16'hC000;
    // 0xC000 + 0xFF -> duty 192.
    run_period(192, 256, "endrop_full");
    run_period(192, 51, "endrop_partial");   // stop after the cnt=50 cycle
    en = 1'b0;
    check_idle(20, "endrop_idle");
    // Drop to the 0xC0FF boundary. A stale err would push this higher.
    sample = 16'hC0FF;
    en = 1'b1;
    run_period(192, 256, "reen_p1");     // err 0 -> duty 192, err 0xFF
    sample = 16'h0001;
    run_period(1, 256, "reen_p2");       // 0x0001 + 0xFF = 0x100 -> duty 1
  endtask

  task automatic test_mid_reset();
    sample = 16'h8000;
    run_period(128, 30, "mrst_partial");
    rst_n = 1'b0;
    check_idle(4, "mrst_idle");
    rst_n = 1'b1;
    run_period(128, 256, "mrst_after");
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    sample = '0;
    #1;
    test_reset();
    test_midscale();
    test_dither();
    test_saturation();
    test_zero();
    test_en_drop();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
